freq_meter: RTL and testbench

//  Measures an asynchronous toggling signal against the local clock: counts rising

---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/freq_meter_sync_edge.sv | 30 +++
 rtl/freq_meter.sv | 111 +++++++++++
 tb/tb_freq_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared FSM state encoding and width helper for the frequency meter.
// Pure declarations: no latency and no flow control.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } fm_state_e;

    // Bits needed to hold 0..value-1. Never less than 1, so a 2-cycle gate still gets a counter.
    function automatic int fm_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Synchronizes an async input and emits a one-cycle pulse on each rising edge.
// Latency: the pulse appears STAGES+1 cycles after the input; there is no backpressure.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_i};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_i over a fixed gate of GATE_CYCLES clocks and window-checks the result.
// Latency: a result every GATE_CYCLES+2 cycles while enabled; there is no backpressure (enable only starts or aborts gates).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1200000,
    parameter int COUNT_WIDTH = 24,
    parameter int LOW_LIMIT   = 0,
    parameter int HIGH_LIMIT  = 2**24-1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sig_i,
    input  logic                   enable,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   count_valid,
    output logic                   in_range,
    output logic                   overflow
);

    localparam int GW = fm_clog2(GATE_CYCLES);
    localparam logic [COUNT_WIDTH:0] LOW_X  = {1'b0, COUNT_WIDTH'(LOW_LIMIT)};
    localparam logic [COUNT_WIDTH:0] HIGH_X = {1'b0, COUNT_WIDTH'(HIGH_LIMIT)};

    logic                   w_rise;
    logic                   w_at_max;
    logic                   w_last;
    logic                   w_sat_nxt;
    logic                   w_lo_borrow;
    logic                   w_hi_borrow;
    logic [COUNT_WIDTH-1:0] w_edge_nxt;

    fm_state_e              r_state;
    logic [GW-1:0]          r_gate_cnt;
    logic [COUNT_WIDTH-1:0] r_edge_cnt;
    logic                   r_sat;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_valid;
    logic                   r_in_range;
    logic                   r_overflow;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
        .clock   (clock),
        .reset   (reset),
        .async_i (sig_i),
        .rise_o  (w_rise)
    );

    assign w_at_max   = &r_edge_cnt;
    assign w_edge_nxt = (w_rise && !w_at_max) ? r_edge_cnt + COUNT_WIDTH'(1) : r_edge_cnt;
    assign w_sat_nxt  = r_sat | (w_rise & w_at_max);
    assign w_last     = (r_gate_cnt == GW'(GATE_CYCLES - 1));

    // Window test by borrow-out of widened subtractions, so an all-ones or zero limit needs no special case.
    assign w_lo_borrow = |(({1'b0, w_edge_nxt} - LOW_X) >> COUNT_WIDTH);
    assign w_hi_borrow = |((HIGH_X - {1'b0, w_edge_nxt}) >> COUNT_WIDTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_in_range <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_ARM;
                end
                ST_ARM: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    r_state    <= enable ? ST_MEASURE : ST_IDLE;
                end
                ST_MEASURE: begin
                    r_gate_cnt <= r_gate_cnt + GW'(1);
                    r_edge_cnt <= w_edge_nxt;
                    r_sat      <= w_sat_nxt;
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        // Results are loaded on entry so they are already valid during the REPORT cycle.
                        r_state    <= ST_REPORT;
                        r_count    <= w_edge_nxt;
                        r_overflow <= w_sat_nxt;
                        r_in_range <= !w_lo_borrow && !w_hi_borrow && !w_sat_nxt;
                        r_valid    <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    r_state <= enable ? ST_ARM : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == ST_ARM) || (r_state == ST_MEASURE);
    assign count_o     = r_count;
    assign count_valid = r_valid;
    assign in_range    = r_in_range;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed sequence with a window-counting reference model over the recorded sig_i history.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int CW   = 8;
    localparam int CW4  = 4;
    localparam int LOW  = 45;
    localparam int HIGH = 55;
    localparam int SS   = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          sig_i;
    logic          enable;
    logic          busy, count_valid, in_range, overflow;
    logic [CW-1:0] count_o;
    logic          busy4, cv4, ir4, ov4;
    logic [CW4-1:0] cnt4;

    always #5 clock = ~clock;

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(CW), .LOW_LIMIT(LOW),
                 .HIGH_LIMIT(HIGH), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .sig_i(sig_i), .enable(enable),
        .busy(busy), .count_o(count_o), .count_valid(count_valid),
        .in_range(in_range), .overflow(overflow));

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(CW4), .LOW_LIMIT(LOW),
                 .HIGH_LIMIT(HIGH), .SYNC_STAGES(SS)) dut4 (
        .clock(clock), .reset(reset), .sig_i(sig_i), .enable(enable),
        .busy(busy4), .count_o(cnt4), .count_valid(cv4),
        .in_range(ir4), .overflow(ov4));

    int            n_asserts = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    int            mode      = 0;
    int            nvalid    = 0;
    int            last_valid = 0;
    logic          sig_man   = 1'b0;
    logic          rst_edge;
    logic          hist [0:4095];
    logic [CW-1:0] prev_cnt;
    logic          prev_ir, prev_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising edges of sig_i whose synchronized pulse lands inside the gate ending just before cycle t.
    function automatic int raw_edges(input int t);
        int n;
        n = 0;
        for (int d = t - GATE; d < t; d++)
            if (hist[d-SS-1] && !hist[d-SS-2]) n++;
        return n;
    endfunction

    task automatic check_report();
        int raw, m8, m4, e8, e4, lo4, hi4;
        raw = raw_edges(cyc);
        m8  = (1 << CW) - 1;
        m4  = (1 << CW4) - 1;
        e8  = (raw > m8) ? m8 : raw;
        e4  = (raw > m4) ? m4 : raw;
        lo4 = LOW & m4;
        hi4 = HIGH & m4;
        chk("rep_cnt8", 32'(count_o), 32'(e8));
        chk("rep_ovf8", 32'(overflow), 32'(raw > m8));
        chk("rep_inr8", 32'(in_range), 32'(raw <= m8 && e8 >= LOW && e8 <= HIGH));
        chk("rep_vld4", 32'(cv4), 32'd1);
        chk("rep_cnt4", 32'(cnt4), 32'(e4));
        chk("rep_ovf4", 32'(ov4), 32'(raw > m4));
        chk("rep_inr4", 32'(ir4), 32'(raw <= m4 && e4 >= lo4 && e4 <= hi4));
    endtask

    task automatic step();
        logic s;
        @(posedge clock);
        cyc++;
        rst_edge = reset;
        #1;
        case (mode)
            0:       s = 1'b0;
            1:       s = 1'b1;
            2:       s = cyc[0];
            3:       s = cyc[1];
            4:       s = 1'($urandom_range(0, 1));
            default: s = sig_man;
        endcase
        sig_i     = s;
        hist[cyc] = s;
        @(negedge clock);
        if (count_valid) begin
            nvalid++;
            last_valid = cyc;
            check_report();
        end else if (!rst_edge) begin
            chk("stable_cnt", 32'(count_o), 32'(prev_cnt));
            chk("stable_inr", 32'(in_range), 32'(prev_ir));
            chk("stable_ovf", 32'(overflow), 32'(prev_ov));
        end
        prev_cnt = count_o;
        prev_ir  = in_range;
        prev_ov  = overflow;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        int n0, k;
        n0 = nvalid;
        k  = 0;
        while (nvalid == n0 && k < max_cycles) begin
            step();
            k++;
        end
        chk(tag, 32'(nvalid - n0), 32'd1);
    endtask

    initial begin
        int c0, t_prev, n0;
        logic [CW-1:0] saved;
        for (int i = 0; i < 4096; i++) hist[i] = 1'b0;
        reset  = 1'b1;
        enable = 1'b0;
        sig_i  = 1'b0;

        repeat (3) step();
        chk("rst_cnt",   32'(count_o), 32'd0);
        chk("rst_valid", 32'(count_valid), 32'd0);
        chk("rst_inr",   32'(in_range), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Period-2 square wave: 50 edges per gate, back-to-back gates every 102 cycles.
        mode = 2; enable = 1'b1; c0 = cyc;
        wait_valid(300, "t1_first");
        chk("t1_first_lat", 32'(last_valid - c0), 32'd102);
        t_prev = last_valid;
        step();
        chk("t1_busy_arm", 32'(busy), 32'd1);
        wait_valid(300, "t1_second");
        chk("t1_period", 32'(last_valid - t_prev), 32'd102);
        chk("t1_cnt",  32'(count_o), 32'd50);
        chk("t1_inr",  32'(in_range), 32'd1);
        chk("t1_ovf",  32'(overflow), 32'd0);
        chk("t3_cnt4", 32'(cnt4), 32'd15);
        chk("t3_ovf4", 32'(ov4), 32'd1);
        chk("t3_inr4", 32'(ir4), 32'd0);

        mode = 3;
        wait_valid(300, "t2_p4_a");
        wait_valid(300, "t2_p4_b");
        chk("t2_p4_cnt", 32'(count_o), 32'd25);
        chk("t2_p4_inr", 32'(in_range), 32'd0);

        mode = 0;
        wait_valid(300, "t2_lo_a");
        wait_valid(300, "t2_lo_b");
        chk("t2_lo_cnt", 32'(count_o), 32'd0);

        mode = 1;
        wait_valid(300, "t2_hi_a");
        wait_valid(300, "t2_hi_b");
        chk("t2_hi_cnt", 32'(count_o), 32'd0);
        chk("t2_hi_inr", 32'(in_range), 32'd0);

        mode = 4;
        repeat (3) wait_valid(300, "rnd_gate");

        // Abort 50 MEASURE cycles into a gate.
        saved = count_o;
        repeat (51) step();
        enable = 1'b0;
        n0 = nvalid;
        step();
        chk("t4_busy_abort", 32'(busy), 32'd0);
        repeat (150) step();
        chk("t4_no_valid", 32'(nvalid - n0), 32'd0);
        chk("t4_kept_cnt", 32'(count_o), 32'(saved));
        enable = 1'b1; c0 = cyc;
        wait_valid(300, "t4_reenable");
        chk("t4_reen_lat", 32'(last_valid - c0), 32'd102);

        // Reset mid-gate after a valid result.
        repeat (30) step();
        reset = 1'b1;
        step();
        chk("t5_cnt",   32'(count_o), 32'd0);
        chk("t5_inr",   32'(in_range), 32'd0);
        chk("t5_ovf",   32'(overflow), 32'd0);
        chk("t5_valid", 32'(count_valid), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        reset = 1'b0; enable = 1'b0;
        repeat (5) step();
        chk("t5_busy_idle", 32'(busy), 32'd0);

        // Single edge whose pulse lands in the ARM cycle: dropped.
        mode = 5; sig_man = 1'b0;
        repeat (10) step();
        sig_man = 1'b1;
        repeat (3) step();
        enable = 1'b1;
        wait_valid(300, "t6_arm");
        chk("t6_arm_cnt", 32'(count_o), 32'd0);
        enable = 1'b0;
        step();
        chk("t6_report_idle", 32'(busy), 32'd0);
        sig_man = 1'b0;
        repeat (10) step();

        // Single edge whose pulse lands in the first MEASURE cycle: counted.
        sig_man = 1'b1;
        repeat (2) step();
        enable = 1'b1;
        wait_valid(300, "t6_meas");
        chk("t6_meas_cnt", 32'(count_o), 32'd1);
        enable = 1'b0;
        step();
        chk("t6_meas_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
